dram_req_arbiter: RTL and testbench

Shares the single DRAM request/data interface (d_req, d_initadr, d_blocks, d_din, d_w, d_douten, d_busy) among NREQ requesters in the sorting core, e.g. the host-data initial writer and the merge-phase readers/writers. It selects requesters round-robin and issues one DRAM access per grant. It steers the write/read data strobes to the granted requester and reports completion. It sits between the requester logic and the DRAM controller.

---
 rtl/dram_req_arbiter_pkg.sv | 23 ++
 rtl/dram_req_arbiter_rr_picker.sv | 28 ++
 rtl/dram_req_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_dram_req_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_req_arbiter_pkg.sv
// Shared DRAM arbiter definitions: data width, request codes and FSM states.
package dram_req_arbiter_pkg;

    localparam int DRAMW = 512;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_WR   = 2'd1,
        REQ_RD   = 2'd2,
        REQ_RSV  = 2'd3
    } req_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_e;

    function automatic logic req_is_access(input logic [1:0] code);
        return (code == REQ_WR) || (code == REQ_RD);
    endfunction

endpackage

// File: rtl/dram_req_arbiter_rr_picker.sv
// Combinational round-robin pick: first valid requester at or after ptr.
module dram_req_arbiter_rr_picker #(
    parameter int NREQ = 2,
    parameter int PTRW = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PTRW-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic            found
);

    int idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && valid[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter: round-robin sharing of one DRAM request/data port.
// Define DRAM_ARB_BEATCHK_EN to add the beat counter and sticky beat_err.
module dram_req_arbiter
    import dram_req_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int DATAW = DRAMW,
    parameter int ADRW  = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [2*NREQ-1:0]     r_req,
    input  logic [ADRW*NREQ-1:0]  r_initadr,
    input  logic [ADRW*NREQ-1:0]  r_blocks,
    input  logic [DATAW*NREQ-1:0] r_din,
    output logic [NREQ-1:0]       r_gnt,
    output logic [NREQ-1:0]       r_w,
    output logic [NREQ-1:0]       r_douten,
    output logic [NREQ-1:0]       r_done,
`ifdef DRAM_ARB_BEATCHK_EN
    output logic                  beat_err,
`endif
    input  logic                  d_busy,
    output logic [1:0]            d_req,
    output logic [ADRW-1:0]       d_initadr,
    output logic [ADRW-1:0]       d_blocks,
    output logic [DATAW-1:0]      d_din,
    input  logic                  d_w,
    input  logic [DATAW-1:0]      d_dout,
    input  logic                  d_douten
);

    localparam int PTRW = $clog2(NREQ);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [1:0]        dreq_q, dreq_d;
    logic [ADRW-1:0]   adr_q, adr_d;
    logic [ADRW-1:0]   blk_q, blk_d;
    logic [PTRW-1:0]   ptr_q, ptr_d;
    logic [PTRW-1:0]   gidx_q, gidx_d;

    logic [NREQ-1:0]   valid;
    logic [NREQ-1:0]   pick_gnt;
    logic              pick_found;
    logic [PTRW-1:0]   pick_idx;
    logic [1:0]        sel_code;
    logic [ADRW-1:0]   sel_adr;
    logic [ADRW-1:0]   sel_blk;
    logic              take;

    // Read data is tapped by requesters directly.
    logic              unused_dout;
    assign unused_dout = ^d_dout;

    always_comb begin
        valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            valid[i] = req_is_access(r_req[2*i +: 2])
                    && (r_blocks[ADRW*i +: ADRW] != '0);
        end
    end

    dram_req_arbiter_rr_picker #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_picker (
        .valid (valid),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .found (pick_found)
    );

    always_comb begin
        pick_idx = '0;
        sel_code = '0;
        sel_adr  = '0;
        sel_blk  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                pick_idx = PTRW'(i);
                sel_code = r_req[2*i +: 2];
                sel_adr  = r_initadr[ADRW*i +: ADRW];
                sel_blk  = r_blocks[ADRW*i +: ADRW];
            end
        end
    end

    // No arbitration in the r_done cycle: the finishing requester is
    // still dropping its request then.
    assign take = (state_q == IDLE) && pick_found && (done_q == '0);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        dreq_d  = dreq_q;
        adr_d   = adr_q;
        blk_d   = blk_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = ISSUE;
                    gnt_d   = pick_gnt;
                    gidx_d  = pick_idx;
                    dreq_d  = sel_code;
                    adr_d   = sel_adr;
                    blk_d   = sel_blk;
                end
            end
            ISSUE: begin
                if (d_busy) begin
                    dreq_d  = REQ_NONE;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!d_busy) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    done_d  = gnt_q;
                    ptr_d   = (gidx_q == PTRW'(NREQ-1)) ? '0
                            : gidx_q + PTRW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            dreq_q  <= REQ_NONE;
            adr_q   <= '0;
            blk_q   <= '0;
            ptr_q   <= '0;
            gidx_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            dreq_q  <= dreq_d;
            adr_q   <= adr_d;
            blk_q   <= blk_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
        end
    end

    assign r_gnt     = gnt_q;
    assign r_done    = done_q;
    assign d_req     = dreq_q;
    assign d_initadr = adr_q;
    assign d_blocks  = blk_q;
    assign r_w       = d_w ? gnt_q : '0;
    assign r_douten  = d_douten ? gnt_q : '0;

    always_comb begin
        d_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) d_din = r_din[DATAW*i +: DATAW];
        end
    end

`ifdef DRAM_ARB_BEATCHK_EN
    logic [ADRW-1:0] cnt_q, cnt_d;
    logic [ADRW-1:0] cnt_inc;
    logic            err_q, err_d;
    logic            beat;

    always_comb begin
        beat    = d_w | d_douten;
        cnt_inc = cnt_q + ADRW'(beat);
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (state_q == IDLE) begin
            if (beat) err_d = 1'b1;
            if (take) cnt_d = '0;
        end else begin
            if (beat) cnt_d = cnt_inc;
            if (state_q == BUSY && !d_busy && cnt_inc != blk_q)
                err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign beat_err = err_q;
`endif

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Randomized + directed bench for dram_req_arbiter against a behavioural model.
// Beat-error checks are active when DRAM_ARB_BEATCHK_EN is defined.
module tb_dram_req_arbiter;

    localparam int NREQ  = 2;
    localparam int DATAW = 512;
    localparam int ADRW  = 32;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b0;
    logic [2*NREQ-1:0]     r_req;
    logic [ADRW*NREQ-1:0]  r_initadr;
    logic [ADRW*NREQ-1:0]  r_blocks;
    logic [DATAW*NREQ-1:0] r_din;
    logic [NREQ-1:0]       r_gnt, r_w, r_douten, r_done;
    logic                  d_busy;
    logic [1:0]            d_req;
    logic [ADRW-1:0]       d_initadr, d_blocks;
    logic [DATAW-1:0]      d_din, d_dout;
    logic                  d_w, d_douten;
`ifdef DRAM_ARB_BEATCHK_EN
    logic                  beat_err;
`endif

    always #5 CLK = ~CLK;

    dram_req_arbiter #(.NREQ(NREQ), .DATAW(DATAW), .ADRW(ADRW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .r_req     (r_req),
        .r_initadr (r_initadr),
        .r_blocks  (r_blocks),
        .r_din     (r_din),
        .r_gnt     (r_gnt),
        .r_w       (r_w),
        .r_douten  (r_douten),
        .r_done    (r_done),
`ifdef DRAM_ARB_BEATCHK_EN
        .beat_err  (beat_err),
`endif
        .d_busy    (d_busy),
        .d_req     (d_req),
        .d_initadr (d_initadr),
        .d_blocks  (d_blocks),
        .d_din     (d_din),
        .d_w       (d_w),
        .d_dout    (d_dout),
        .d_douten  (d_douten)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [DATAW-1:0] act,
                       input logic [DATAW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one owner at a time, rr pointer as an integer.
    logic [NREQ-1:0] m_gnt, m_done;
    logic [1:0]      m_dreq;
    logic [ADRW-1:0] m_adr, m_blk;
    int              m_owner, m_ptr, m_beats;
    bit              m_issued, m_err, m_was_done, m_beat;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_gnt = '0; m_done = '0; m_dreq = '0; m_adr = '0; m_blk = '0;
            m_owner = -1; m_ptr = 0; m_beats = 0; m_issued = 0; m_err = 0;
        end else begin
            m_was_done = (m_done != '0);
            m_beat = d_w | d_douten;
            m_done = '0;
            if (m_owner < 0) begin
                if (m_beat) m_err = 1;
                if (!m_was_done) begin
                    for (int k = 0; k < NREQ; k++) begin
                        int i;
                        i = (m_ptr + k) % NREQ;
                        if (m_owner < 0
                            && (r_req[2*i +: 2] == 2'd1 || r_req[2*i +: 2] == 2'd2)
                            && r_blocks[ADRW*i +: ADRW] != '0) begin
                            m_owner  = i;
                            m_gnt    = NREQ'(1) << i;
                            m_dreq   = r_req[2*i +: 2];
                            m_adr    = r_initadr[ADRW*i +: ADRW];
                            m_blk    = r_blocks[ADRW*i +: ADRW];
                            m_issued = 0;
                            m_beats  = 0;
                        end
                    end
                end
            end else begin
                if (m_beat) m_beats++;
                if (!m_issued) begin
                    if (d_busy) begin
                        m_issued = 1;
                        m_dreq   = '0;
                    end
                end else if (!d_busy) begin
                    if (m_beats != int'(m_blk)) m_err = 1;
                    m_done  = m_gnt;
                    m_gnt   = '0;
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_owner = -1;
                end
            end
        end
    end

    // Compare process plus event counters used by the literal checks.
    int rw_cnt[NREQ], rd_cnt[NREQ], done_cnt[NREQ], gnt_cyc[NREQ];
    int dreq_cyc = 0;
    int done_log[$];
    logic [DATAW-1:0] exp_din;

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            rw_cnt[i] = 0; rd_cnt[i] = 0; done_cnt[i] = 0; gnt_cyc[i] = 0;
        end
    end

    always @(negedge CLK) begin
        exp_din = '0;
        for (int i = 0; i < NREQ; i++)
            if (m_gnt[i]) exp_din = r_din[DATAW*i +: DATAW];
        chk("r_gnt", DATAW'(r_gnt), DATAW'(m_gnt));
        chk("r_done", DATAW'(r_done), DATAW'(m_done));
        chk("d_req", DATAW'(d_req), DATAW'(m_dreq));
        chk("d_initadr", DATAW'(d_initadr), DATAW'(m_adr));
        chk("d_blocks", DATAW'(d_blocks), DATAW'(m_blk));
        chk("r_w", DATAW'(r_w), DATAW'(d_w ? m_gnt : '0));
        chk("r_douten", DATAW'(r_douten), DATAW'(d_douten ? m_gnt : '0));
        chk("d_din", d_din, exp_din);
`ifdef DRAM_ARB_BEATCHK_EN
        chk("beat_err", DATAW'(beat_err), DATAW'(m_err));
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (r_w[i]) rw_cnt[i]++;
            if (r_douten[i]) rd_cnt[i]++;
            if (r_gnt[i]) gnt_cyc[i]++;
            if (r_done[i]) begin
                done_cnt[i]++;
                done_log.push_back(i);
            end
        end
        if (d_req != 2'd0) dreq_cyc++;
    end

    // DRAM controller model.
    int   bfm_lat  = 0;
    int   bfm_over = -1;
    bit   bfm_pre  = 0;
    logic [1:0] bfm_code;
    int   bfm_n;

    initial begin
        d_busy = 0; d_w = 0; d_douten = 0;
        forever begin
            @(negedge CLK); #1;
            d_busy = bfm_pre; d_w = 0; d_douten = 0;
            if (!RST && d_req != 2'd0) begin
                bfm_code = d_req;
                bfm_n = (d_blocks > 16) ? 16 : int'(d_blocks);
                if (bfm_over >= 0) bfm_n = bfm_over;
                for (int t = 0; t < bfm_lat && !RST; t++) begin
                    @(negedge CLK); #1;
                end
                d_busy = 1;
                for (int b = 0; b < bfm_n && !RST; b++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        @(negedge CLK); #1;
                    end
                    d_w = (bfm_code == 2'd1);
                    d_douten = (bfm_code == 2'd2);
                    @(negedge CLK); #1;
                    d_w = 0; d_douten = 0;
                end
                d_busy = 0;
            end
        end
    end

    task automatic tick();
        @(negedge CLK); #1;
    endtask

    function automatic logic [DATAW-1:0] rnd_data();
        logic [DATAW-1:0] v;
        for (int k = 0; k < DATAW/32; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    task automatic set_req(input int i, input logic [1:0] c,
                           input logic [ADRW-1:0] a, input logic [ADRW-1:0] b);
        r_req[2*i +: 2]             = c;
        r_initadr[ADRW*i +: ADRW]   = a;
        r_blocks[ADRW*i +: ADRW]    = b;
        r_din[DATAW*i +: DATAW]     = rnd_data();
    endtask

    task automatic clr_req(input int i);
        r_req[2*i +: 2] = 2'd0;
    endtask

    task automatic wait_done(input int i, input string name);
        int t;
        t = 0;
        while (r_done[i] !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        chk(name, DATAW'(r_done[i]), DATAW'(1));
        clr_req(i);
    endtask

    task automatic do_reset();
        RST = 1;
        tick(); tick();
        RST = 0;
        tick();
    endtask

    int s_a, s_b, s_c, s_log;
    bit act[NREQ], inv[NREQ], rearm[NREQ];
    int c;

    initial begin
        r_req = '0; r_initadr = '0; r_blocks = '0; r_din = '0;
        d_dout = rnd_data();
        #1 RST = 1;
        @(negedge CLK); #1;
        chk("rst_gnt", DATAW'(r_gnt), '0);
        chk("rst_done", DATAW'(r_done), '0);
        chk("rst_dreq", DATAW'(d_req), '0);
        chk("rst_din", d_din, '0);
        tick();
        RST = 0;
        tick();

        // Single 4-beat write from requester 0, busy 2 cycles after d_req.
        bfm_lat = 2;
        s_a = rw_cnt[0]; s_b = done_cnt[0]; s_c = dreq_cyc;
        set_req(0, 2'd1, 32'h100, 32'd4);
        wait_done(0, "t1_done_seen");
        tick(); tick();
        chk("t1_w_beats", DATAW'(rw_cnt[0] - s_a), DATAW'(4));
        chk("t1_done_cnt", DATAW'(done_cnt[0] - s_b), DATAW'(1));
        chk("t1_dreq_cycles", DATAW'(dreq_cyc - s_c), DATAW'(3));

        // Simultaneous reads from a fresh pointer alternate 0,1,0,1.
        do_reset();
        bfm_lat = 1;
        s_log = done_log.size();
        set_req(0, 2'd2, 32'h200, 32'd2);
        set_req(1, 2'd2, 32'h300, 32'd3);
        rearm[0] = 0; rearm[1] = 0;
        for (int t = 0; t < 300 && done_log.size() < s_log + 4; t++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (r_done[i]) begin
                    clr_req(i);
                    rearm[i] = 1;
                end else if (rearm[i]) begin
                    set_req(i, 2'd2, 32'h200 + 32'(i), 32'd2);
                    rearm[i] = 0;
                end
            end
        end
        clr_req(0); clr_req(1);
        for (int k = 0; k < 4; k++) begin
            int want, got;
            want = k % 2;
            got = (done_log.size() > s_log + k) ? done_log[s_log + k] : -1;
            chk("t2_order", DATAW'(got), DATAW'(want));
        end
        repeat (20) tick();

        // Zero-block request is never granted.
        s_a = gnt_cyc[1]; s_b = done_cnt[1]; s_c = done_cnt[0];
        set_req(1, 2'd2, 32'h400, 32'd0);
        set_req(0, 2'd1, 32'h500, 32'd3);
        wait_done(0, "t3_done_seen");
        repeat (8) tick();
        clr_req(1);
        chk("t3_gnt1_cycles", DATAW'(gnt_cyc[1] - s_a), '0);
        chk("t3_done1", DATAW'(done_cnt[1] - s_b), '0);
        chk("t3_done0", DATAW'(done_cnt[0] - s_c), DATAW'(1));

        // d_busy already high at grant: d_req lasts one cycle.
        bfm_pre = 1; bfm_lat = 1;
        tick(); tick();
        s_a = dreq_cyc; s_b = done_cnt[1];
        set_req(1, 2'd2, 32'h600, 32'd2);
        wait_done(1, "t4_done_seen");
        bfm_pre = 0;
        tick(); tick();
        chk("t4_dreq_cycles", DATAW'(dreq_cyc - s_a), DATAW'(1));
        chk("t4_done_cnt", DATAW'(done_cnt[1] - s_b), DATAW'(1));

        // Short beat count: 4 blocks, only 3 read beats.
        bfm_over = 3; bfm_lat = 0;
        tick();
        set_req(0, 2'd2, 32'h700, 32'd4);
        wait_done(0, "t5_done_seen");
        tick();
        bfm_over = -1;
`ifdef DRAM_ARB_BEATCHK_EN
        chk("t5_err_set", DATAW'(beat_err), DATAW'(1));
        repeat (5) tick();
        chk("t5_err_sticky", DATAW'(beat_err), DATAW'(1));
`endif
        do_reset();
`ifdef DRAM_ARB_BEATCHK_EN
        chk("t5_err_cleared", DATAW'(beat_err), '0);
`endif
        set_req(0, 2'd2, 32'h780, 32'd4);
        wait_done(0, "t5b_done_seen");
        tick();
`ifdef DRAM_ARB_BEATCHK_EN
        chk("t5b_err_clear", DATAW'(beat_err), '0);
`endif

        // Asynchronous reset in the middle of the beats.
        s_a = rd_cnt[0];
        set_req(0, 2'd2, 32'h800, 32'd6);
        for (int t = 0; t < 100 && rd_cnt[0] - s_a < 2; t++) tick();
        @(posedge CLK); #2;
        RST = 1;
        #1;
        chk("t6_gnt", DATAW'(r_gnt), '0);
        chk("t6_done", DATAW'(r_done), '0);
        chk("t6_dreq", DATAW'(d_req), '0);
        chk("t6_adr", DATAW'(d_initadr), '0);
        chk("t6_blk", DATAW'(d_blocks), '0);
        chk("t6_rw", DATAW'(r_w), '0);
        chk("t6_rdo", DATAW'(r_douten), '0);
        chk("t6_din", d_din, '0);
        clr_req(0);
        tick(); tick();
        RST = 0;
        tick();
        s_a = rw_cnt[1]; s_b = done_cnt[1];
        set_req(1, 2'd1, 32'h900, 32'd3);
        wait_done(1, "t6_after_done");
        tick();
        chk("t6_after_beats", DATAW'(rw_cnt[1] - s_a), DATAW'(3));
        chk("t6_after_cnt", DATAW'(done_cnt[1] - s_b), DATAW'(1));

        // Random traffic from both requesters against the model.
        for (int i = 0; i < NREQ; i++) begin act[i] = 0; inv[i] = 0; end
        for (int t = 0; t < 600; t++) begin
            tick();
            bfm_lat = $urandom_range(0, 3);
            bfm_pre = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (r_done[i]) begin
                    clr_req(i);
                    act[i] = 0;
                end else if (act[i] && inv[i] && $urandom_range(0, 3) == 0) begin
                    clr_req(i);
                    act[i] = 0;
                end else if (!act[i] && $urandom_range(0, 2) == 0) begin
                    c = $urandom_range(0, 5);
                    if (c == 4) c = 1;
                    if (c == 5) c = 2;
                    set_req(i, 2'(c), $urandom, 32'($urandom_range(0, 5)));
                    act[i] = 1;
                    inv[i] = !(c == 1 || c == 2) || r_blocks[ADRW*i +: ADRW] == '0;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) clr_req(i);
        bfm_pre = 0;
        repeat (60) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
